// File: rtl/controle_nave.sv
// Player-ship motion controller: synchronizes the direction buttons, produces a
// per-frame movement tick and updates the ship position with a speed ramp.
// Optional macro NAVE_WRAP_EN: horizontal motion wraps around instead of clamping.
module controle_nave #(
  parameter int LARGURA     = 32,
  parameter int ALTURA      = 16,
  parameter int X_INI       = 304,
  parameter int Y_INI       = 440,
  parameter int TICK_CICLOS = 833333,
  parameter int VEL_MIN     = 1,
  parameter int VEL_MAX     = 8,
  parameter int RAMPA_TICKS = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       btn_esq,
  input  logic       btn_dir,
  input  logic       btn_cima,
  input  logic       btn_baixo,
  output logic [9:0] xNave,
  output logic [9:0] yNave,
  output logic [9:0] larguraNave,
  output logic [9:0] alturaNave,
  output logic       tick,
  output logic       movendo
);

  localparam int CW = (TICK_CICLOS > 1) ? $clog2(TICK_CICLOS) : 1;
  localparam int RW = (RAMPA_TICKS > 1) ? $clog2(RAMPA_TICKS) : 1;
  localparam int VW = $clog2(VEL_MAX + 1);

  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CICLOS - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMPA_TICKS - 1);
  localparam logic [VW-1:0] VMIN      = VW'(VEL_MIN);
  localparam logic [VW-1:0] VMAX      = VW'(VEL_MAX);
  localparam logic [10:0]   XMAX      = 11'(639 - LARGURA);
  localparam logic [10:0]   YMAX      = 11'(479 - ALTURA);

  typedef enum logic [1:0] {
    PARADO     = 2'd0,
    ACELERANDO = 2'd1,
    CRUZEIRO   = 2'd2
  } estado_t;

  logic [3:0]    sync1_r;
  logic [3:0]    sync2_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          tick_r;
  logic [9:0]    x_r;
  logic [9:0]    y_r;
  logic [9:0]    x_nxt_s;
  logic [9:0]    y_nxt_s;
  logic [VW-1:0] vel_r;
  logic [VW-1:0] vel_nxt_s;
  logic [VW-1:0] vel_inc_s;
  logic [RW-1:0] ramp_r;
  logic [RW-1:0] ramp_nxt_s;
  logic          ramp_fim_s;
  logic          movendo_r;
  estado_t       state_r;
  estado_t       state_nxt_s;

  logic          mv_esq_s;
  logic          mv_dir_s;
  logic          mv_cima_s;
  logic          mv_baixo_s;
  logic          moving_s;
  logic [10:0]   x_ext_s;
  logic [10:0]   y_ext_s;
  logic [10:0]   vel_ext_s;
  logic [10:0]   x_soma_s;
  logic [10:0]   y_soma_s;

  // Two-flop synchronizer for {esq, dir, cima, baixo}
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= {btn_esq, btn_dir, btn_cima, btn_baixo};
      sync2_r <= sync1_r;
    end
  end

  // Next value of the frame-period counter
  always_comb begin
    if (cnt_r == TICK_LAST) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
  end

  // tick is registered so it is high exactly while the counter holds its last value
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= (cnt_nxt_s == TICK_LAST);
    end
  end

  assign mv_esq_s   = sync2_r[3] & ~sync2_r[2];
  assign mv_dir_s   = sync2_r[2] & ~sync2_r[3];
  assign mv_cima_s  = sync2_r[1] & ~sync2_r[0];
  assign mv_baixo_s = sync2_r[0] & ~sync2_r[1];
  assign moving_s   = mv_esq_s | mv_dir_s | mv_cima_s | mv_baixo_s;

  assign x_ext_s   = {1'b0, x_r};
  assign y_ext_s   = {1'b0, y_r};
  assign vel_ext_s = 11'(vel_r);
  assign x_soma_s  = x_ext_s + vel_ext_s;
  assign y_soma_s  = y_ext_s + vel_ext_s;

  // Horizontal displacement with clamping (or wrap-around when enabled)
  always_comb begin
    x_nxt_s = x_r;
    if (mv_dir_s) begin
      if (x_soma_s > XMAX) begin
`ifdef NAVE_WRAP_EN
        x_nxt_s = 10'(x_soma_s - (XMAX + 11'd1));
`else
        x_nxt_s = 10'(XMAX);
`endif
      end else begin
        x_nxt_s = 10'(x_soma_s);
      end
    end else if (mv_esq_s) begin
      if (x_ext_s < vel_ext_s) begin
`ifdef NAVE_WRAP_EN
        x_nxt_s = 10'(x_ext_s + XMAX + 11'd1 - vel_ext_s);
`else
        x_nxt_s = 10'd0;
`endif
      end else begin
        x_nxt_s = 10'(x_ext_s - vel_ext_s);
      end
    end else begin
      x_nxt_s = x_r;
    end
  end

  // Vertical displacement, always clamped to 0..YMAX
  always_comb begin
    y_nxt_s = y_r;
    if (mv_baixo_s) begin
      if (y_soma_s > YMAX) begin
        y_nxt_s = 10'(YMAX);
      end else begin
        y_nxt_s = 10'(y_soma_s);
      end
    end else if (mv_cima_s) begin
      if (y_ext_s < vel_ext_s) begin
        y_nxt_s = 10'd0;
      end else begin
        y_nxt_s = 10'(y_ext_s - vel_ext_s);
      end
    end else begin
      y_nxt_s = y_r;
    end
  end

  assign ramp_fim_s = (ramp_r == RAMP_LAST);
  assign vel_inc_s  = vel_r + VW'(1);

  // Speed FSM state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r <= PARADO;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Speed FSM next state; the first moving tick from rest already counts toward the ramp
  always_comb begin
    state_nxt_s = state_r;
    if (!tick_r) begin
      state_nxt_s = state_r;
    end else if (!moving_s) begin
      state_nxt_s = PARADO;
    end else begin
      case (state_r)
        PARADO, ACELERANDO: begin
          if (ramp_fim_s && (vel_inc_s == VMAX)) begin
            state_nxt_s = CRUZEIRO;
          end else begin
            state_nxt_s = ACELERANDO;
          end
        end
        CRUZEIRO: state_nxt_s = CRUZEIRO;
        default:  state_nxt_s = PARADO;
      endcase
    end
  end

  // Speed FSM outputs: next speed and ramp count
  always_comb begin
    vel_nxt_s  = vel_r;
    ramp_nxt_s = ramp_r;
    if (!tick_r) begin
      vel_nxt_s  = vel_r;
      ramp_nxt_s = ramp_r;
    end else if (!moving_s) begin
      vel_nxt_s  = VMIN;
      ramp_nxt_s = '0;
    end else begin
      case (state_r)
        PARADO, ACELERANDO: begin
          if (ramp_fim_s) begin
            vel_nxt_s  = vel_inc_s;
            ramp_nxt_s = '0;
          end else begin
            vel_nxt_s  = vel_r;
            ramp_nxt_s = ramp_r + RW'(1);
          end
        end
        CRUZEIRO: begin
          vel_nxt_s  = VMAX;
          ramp_nxt_s = '0;
        end
        default: begin
          vel_nxt_s  = VMIN;
          ramp_nxt_s = '0;
        end
      endcase
    end
  end

  // Position, speed and status update together on the edge that ends the tick cycle
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      x_r       <= 10'(X_INI);
      y_r       <= 10'(Y_INI);
      vel_r     <= VMIN;
      ramp_r    <= '0;
      movendo_r <= 1'b0;
    end else begin
      if (tick_r) begin
        x_r <= x_nxt_s;
        y_r <= y_nxt_s;
      end else begin
        x_r <= x_r;
        y_r <= y_r;
      end
      vel_r     <= vel_nxt_s;
      ramp_r    <= ramp_nxt_s;
      movendo_r <= (state_nxt_s != PARADO);
    end
  end

  assign xNave       = x_r;
  assign yNave       = y_r;
  assign larguraNave = 10'(LARGURA);
  assign alturaNave  = 10'(ALTURA);
  assign tick        = tick_r;
  assign movendo     = movendo_r;

endmodule
